// File: rtl/johnson_decoder_pkg.sv
// Shared types and Johnson-code helpers for the johnson_decoder receive checker.
// Helpers take a zero-extended code plus its real width so one function serves any WIDTH < 32.
package johnson_decoder_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQ      = 2'd1,
        LOCKED   = 2'd2
    } jd_state_e;

    localparam int unsigned JC_MAX_W = 32;

    function automatic logic jc_msb(input logic [JC_MAX_W-1:0] code, input int unsigned w);
        return |(code & (JC_MAX_W'(1) << (w - 1)));
    endfunction

    // Legal codes are a run of ones anchored at bit 0, either directly or after inversion.
    function automatic logic jc_legal(input logic [JC_MAX_W-1:0] code, input int unsigned w);
        logic [JC_MAX_W-1:0] mask;
        logic [JC_MAX_W-1:0] v;
        mask = (JC_MAX_W'(1) << w) - JC_MAX_W'(1);
        v    = jc_msb(code, w) ? (~code & mask) : (code & mask);
        return (v & (v + JC_MAX_W'(1))) == '0;
    endfunction

    function automatic int unsigned jc_index(input logic [JC_MAX_W-1:0] code, input int unsigned w);
        logic [JC_MAX_W-1:0] mask;
        int unsigned         ones;
        mask = (JC_MAX_W'(1) << w) - JC_MAX_W'(1);
        ones = int'($countones(code & mask));
        return jc_msb(code, w) ? (2 * w - ones) : ones;
    endfunction

endpackage

// File: rtl/johnson_decoder_code_decode.sv
// Combinational Johnson-code classifier: legality flag and binary state index.
module johnson_code_decode
    import johnson_decoder_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic [WIDTH-1:0] code,
    output logic             legal,
    output logic [CNT_W-1:0] idx
);

    logic [JC_MAX_W-1:0] code_ext;

    always_comb begin
        code_ext = JC_MAX_W'(code);
        legal    = jc_legal(code_ext, WIDTH);
        idx      = CNT_W'(jc_index(code_ext, WIDTH));
    end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code receive checker: decode, sequence tracking, lock FSM, saturating error count.
// state    | meaning
// UNLOCKED | no trusted reference; next legal sample seeds the run
// ACQ      | counting consecutive in-order samples toward LOCK_N
// LOCKED   | sequence trusted; an out-of-order sample is a step error
module johnson_decoder
    import johnson_decoder_pkg::*;
#(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned CNT_W      = 3,
    parameter int unsigned LOCK_N     = 3,
    parameter int unsigned ERR_W      = 8,
    parameter bit          ALLOW_HOLD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    input  logic             in_valid,
    output logic [CNT_W-1:0] count,
    output logic             count_vld,
    output logic             illegal,
    output logic             step_err,
    output logic             locked,
    output logic [ERR_W-1:0] err_count
);

    // One spare count of headroom so run_inc never wraps before the >= compare.
    localparam int unsigned      RUN_W    = $clog2(LOCK_N + 2);
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_N);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(2 * WIDTH - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    jd_state_e        state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d, run_inc;
    logic [CNT_W-1:0] exp_q, exp_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             count_vld_q, count_vld_d;
    logic             illegal_q, illegal_d;
    logic             step_err_q, step_err_d;
    logic             locked_q, locked_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic             dec_legal;
    logic [CNT_W-1:0] dec_idx;
    logic             in_seq;
    logic             err_bump;

    johnson_code_decode #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_decode (
        .code  (i),
        .legal (dec_legal),
        .idx   (dec_idx)
    );

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        exp_d       = exp_q;
        count_d     = count_q;
        count_vld_d = 1'b0;
        illegal_d   = 1'b0;
        step_err_d  = 1'b0;
        err_d       = err_q;
        err_bump    = 1'b0;
        run_inc     = run_q + RUN_W'(1);
        in_seq      = (dec_idx == exp_q) ||
                      (ALLOW_HOLD && (dec_idx == count_q) && (state_q != UNLOCKED));

        if (in_valid) begin
            if (!dec_legal) begin
                illegal_d = 1'b1;
                state_d   = UNLOCKED;
                run_d     = '0;
                err_bump  = 1'b1;
            end else begin
                count_d     = dec_idx;
                count_vld_d = 1'b1;
                exp_d       = (dec_idx == LAST_IDX) ? '0 : dec_idx + 1'b1;
                unique case (state_q)
                    UNLOCKED: begin
                        run_d   = RUN_W'(1);
                        state_d = (LOCK_N == 1) ? LOCKED : ACQ;
                    end
                    ACQ: begin
                        if (in_seq) begin
                            run_d   = run_inc;
                            state_d = (run_inc >= RUN_LOCK) ? LOCKED : ACQ;
                        end else begin
                            run_d = RUN_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (!in_seq) begin
                            step_err_d = 1'b1;
                            err_bump   = 1'b1;
                            state_d    = ACQ;
                            run_d      = RUN_W'(1);
                        end
                    end
                    default: begin
                        state_d = UNLOCKED;
                        run_d   = '0;
                    end
                endcase
            end
        end

        if (err_bump && (err_q != ERR_MAX)) begin
            err_d = err_q + 1'b1;
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= UNLOCKED;
            run_q       <= '0;
            exp_q       <= '0;
            count_q     <= '0;
            count_vld_q <= 1'b0;
            illegal_q   <= 1'b0;
            step_err_q  <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            exp_q       <= exp_d;
            count_q     <= count_d;
            count_vld_q <= count_vld_d;
            illegal_q   <= illegal_d;
            step_err_q  <= step_err_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    assign count     = count_q;
    assign count_vld = count_vld_q;
    assign illegal   = illegal_q;
    assign step_err  = step_err_q;
    assign locked    = locked_q;
    assign err_count = err_q;

endmodule
